// File: rtl/vga_draw_bar_graph_pkg.sv
// Shared types and defaults for the bar-graph overlay stage: VGA bus layout,
// default geometry/colours and the frame-update FSM state type.
package vga_draw_bar_graph_pkg;

  localparam int VGA_BUS_SIZE = 38;

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;

  localparam logic [11:0] DEF_BAR_COLOR  = 12'h0_f_0;
  localparam logic [11:0] DEF_PEAK_COLOR = 12'hf_0_0;
  localparam int          DEF_X0         = 64;
  localparam int          DEF_Y0         = 600;
  localparam int          DEF_BAR_W      = 40;
  localparam int          DEF_BAR_GAP    = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_UPD  = 1'b1
  } upd_state_t;

  // Index width for a channel count; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_bar_frame_update.sv
// Per-channel bar state: value writes, once-per-frame smoothing of the displayed
// height and a decaying peak marker, plus read ports for the pixel pipeline.
module vga_bar_frame_update
  import vga_draw_bar_graph_pkg::*;
#(
  parameter int CHANNELS     = 13,
  parameter int VALUE_W      = 12,
  parameter int HEIGHT_W     = 8,
  parameter int SMOOTH_SHIFT = 0,
  parameter int CH_W         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vblnk_in,
  input  logic [VALUE_W-1:0]  value_data,
  input  logic [3:0]          value_ch,
  input  logic                value_valid,
  output logic                value_ready,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [HEIGHT_W-1:0] rd_disp,
  output logic [HEIGHT_W-1:0] rd_peak
);

  logic [HEIGHT_W-1:0] r_target [CHANNELS];
  logic [HEIGHT_W-1:0] r_disp   [CHANNELS];
  logic [HEIGHT_W-1:0] r_peak   [CHANNELS];

  upd_state_t          r_state, w_state_nxt;
  logic [CH_W-1:0]     r_idx, w_idx_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_vblnk;
  logic                w_trigger;
  logic                w_wr;
  logic                w_ch_ok;
  logic                w_rd_ok;
  logic                w_unused_bits;

  logic signed [HEIGHT_W:0] w_diff;
  logic signed [HEIGHT_W:0] w_step;
  logic [HEIGHT_W-1:0]      w_new_disp;
  logic [HEIGHT_W-1:0]      w_new_peak;

  assign w_trigger     = vblnk_in & ~r_vblnk;
  assign w_wr          = value_valid & r_ready;
  assign w_ch_ok       = ({1'b0, value_ch} < 5'(CHANNELS));
  assign w_rd_ok       = ({1'b0, rd_ch} < (CH_W+1)'(CHANNELS));
  assign value_ready   = r_ready;
  assign rd_disp       = w_rd_ok ? r_disp[rd_ch] : '0;
  assign rd_peak       = w_rd_ok ? r_peak[rd_ch] : '0;
  assign w_unused_bits = &{1'b0, value_data};

  // Next-state logic: one channel per cycle while updating.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_state_nxt = ST_UPD;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = r_idx;
        end
      end
      ST_UPD: begin
        if (r_idx == CH_W'(CHANNELS - 1)) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = ST_UPD;
          w_idx_nxt   = r_idx + CH_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
    w_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  // Smoothing step with a forced unit step so small residues still converge.
  always_comb begin
    w_diff = $signed({1'b0, r_target[r_idx]}) - $signed({1'b0, r_disp[r_idx]});
    w_step = w_diff >>> SMOOTH_SHIFT;
    if ((w_step == '0) && (w_diff != '0)) begin
      w_step = w_diff[HEIGHT_W] ? '1 : (HEIGHT_W+1)'(1);
    end else begin
      w_step = w_step;
    end
    w_new_disp = r_disp[r_idx] + w_step[HEIGHT_W-1:0];
    if (w_new_disp > r_peak[r_idx]) begin
      w_new_peak = w_new_disp;
    end else if (r_peak[r_idx] != '0) begin
      w_new_peak = r_peak[r_idx] - HEIGHT_W'(1);
    end else begin
      w_new_peak = r_peak[r_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_vblnk <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ready <= w_ready_nxt;
      r_vblnk <= vblnk_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_target[i] <= '0;
        r_disp[i]   <= '0;
        r_peak[i]   <= '0;
      end
    end else begin
      if (w_wr && w_ch_ok) begin
        r_target[value_ch[CH_W-1:0]] <= value_data[VALUE_W-1 -: HEIGHT_W];
      end
      if (r_state == ST_UPD) begin
        r_disp[r_idx] <= w_new_disp;
        r_peak[r_idx] <= w_new_peak;
      end
    end
  end

endmodule

// File: rtl/vga_draw_bar_graph.sv
// VGA overlay stage drawing one vertical bar per channel with a peak marker.
// Two-stage pixel pipeline; bar state lives in vga_bar_frame_update.
module vga_draw_bar_graph
  import vga_draw_bar_graph_pkg::*;
#(
  parameter int          CHANNELS     = 13,
  parameter int          VALUE_W      = 12,
  parameter int          HEIGHT_W     = 8,
  parameter int          X0           = DEF_X0,
  parameter int          Y0           = DEF_Y0,
  parameter int          BAR_W        = DEF_BAR_W,
  parameter int          BAR_GAP      = DEF_BAR_GAP,
  parameter int          SMOOTH_SHIFT = 0,
  parameter logic [11:0] BAR_COLOR    = DEF_BAR_COLOR,
  parameter logic [11:0] PEAK_COLOR   = DEF_PEAK_COLOR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [VGA_BUS_SIZE-1:0] vga_in,
  output logic [VGA_BUS_SIZE-1:0] vga_out,
  input  logic [VALUE_W-1:0]      value_data,
  input  logic [3:0]              value_ch,
  input  logic                    value_valid,
  output logic                    value_ready
);

  localparam int          PITCH   = BAR_W + BAR_GAP;
  localparam int          CH_W    = ch_width(CHANNELS);
  localparam logic [11:0] X_START = 12'(X0);
  localparam logic [11:0] X_END   = 12'(X0 + CHANNELS * PITCH);
  localparam logic [11:0] Y_BASE  = 12'(Y0);

  vga_bus_t            w_in, r_s1, r_s2, w_out;
  logic [11:0]         w_h, w_base, w_v, w_peak_top;
  logic [CH_W-1:0]     w_ch, r_ch;
  logic                w_col, r_col;
  logic                w_peak_hit, w_bar_hit;
  logic [11:0]         w_rgb;
  logic [HEIGHT_W-1:0] w_disp, w_peak;

  assign w_in    = vga_in;
  assign vga_out = r_s2;

  // Pitch tracker: compare against constant bar origins instead of dividing.
  always_comb begin
    w_h    = {1'b0, w_in.hcount};
    w_ch   = '0;
    w_base = X_START;
    for (int k = 1; k < CHANNELS; k++) begin
      w_ch   = (w_h >= 12'(X0 + k * PITCH)) ? CH_W'(k) : w_ch;
      w_base = (w_h >= 12'(X0 + k * PITCH)) ? 12'(X0 + k * PITCH) : w_base;
    end
    w_col = (w_h >= X_START) && (w_h < X_END) && ((w_h - w_base) < 12'(BAR_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= '0;
      r_ch  <= '0;
      r_col <= 1'b0;
    end else begin
      r_s1  <= w_in;
      r_ch  <= w_ch;
      r_col <= w_col;
    end
  end

  vga_bar_frame_update #(
    .CHANNELS    (CHANNELS),
    .VALUE_W     (VALUE_W),
    .HEIGHT_W    (HEIGHT_W),
    .SMOOTH_SHIFT(SMOOTH_SHIFT),
    .CH_W        (CH_W)
  ) u_update (
    .clk        (clk),
    .rst_n      (rst_n),
    .vblnk_in   (w_in.vblnk),
    .value_data (value_data),
    .value_ch   (value_ch),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .rd_ch      (r_ch),
    .rd_disp    (w_disp),
    .rd_peak    (w_peak)
  );

  // Pixel rule: blanking passes through, the peak marker wins over the bar.
  always_comb begin
    w_v        = {1'b0, r_s1.vcount};
    w_peak_top = Y_BASE - 12'(w_peak);
    w_peak_hit = r_col && (w_peak != '0) &&
                 ((w_v == w_peak_top) || (w_v == w_peak_top - 12'd1));
    w_bar_hit  = r_col && (w_v > Y_BASE - 12'(w_disp)) && (w_v <= Y_BASE);
    if (r_s1.hblnk || r_s1.vblnk) begin
      w_rgb = r_s1.rgb;
    end else if (w_peak_hit) begin
      w_rgb = PEAK_COLOR;
    end else if (w_bar_hit) begin
      w_rgb = BAR_COLOR;
    end else begin
      w_rgb = r_s1.rgb;
    end
    w_out     = r_s1;
    w_out.rgb = w_rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2 <= '0;
    end else begin
      r_s2 <= w_out;
    end
  end

endmodule

// File: tb/tb_vga_draw_bar_graph.sv
// Directed bench for vga_draw_bar_graph: one unsmoothed and one smoothed
// instance share stimulus; expected pixels are hand-computed from geometry.
module tb_vga_draw_bar_graph;
  import vga_draw_bar_graph_pkg::*;

  localparam logic [11:0] BG  = 12'h1_8_9;
  localparam logic [11:0] BAR = 12'h0_f_0;
  localparam logic [11:0] PK  = 12'hf_0_0;

  logic clk = 1'b0;
  logic rst_n;
  vga_bus_t bus_in, out0, out2;
  logic [VGA_BUS_SIZE-1:0] vin, vout0, vout2;
  logic [11:0] vdata;
  logic [3:0]  vch;
  logic        vvalid;
  logic        rdy0, rdy2;
  int n_cmp = 0;
  int n_err = 0;

  assign vin  = bus_in;
  assign out0 = vout0;
  assign out2 = vout2;

  always #5 clk = ~clk;

  vga_draw_bar_graph #(.SMOOTH_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .vga_in(vin), .vga_out(vout0),
    .value_data(vdata), .value_ch(vch), .value_valid(vvalid), .value_ready(rdy0)
  );

  vga_draw_bar_graph #(.SMOOTH_SHIFT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .vga_in(vin), .vga_out(vout2),
    .value_data(vdata), .value_ch(vch), .value_valid(vvalid), .value_ready(rdy2)
  );

  task automatic sample_px(input int sel, input int h, input int v, input logic hb,
                           output logic [11:0] rgb);
    @(negedge clk);
    bus_in        = '0;
    bus_in.hcount = 11'(h);
    bus_in.vcount = 11'(v);
    bus_in.hblnk  = hb;
    bus_in.rgb    = BG;
    repeat (2) @(negedge clk);
    rgb = (sel == 2) ? out2.rgb : out0.rgb;
  endtask

  task automatic run_frame();
    @(negedge clk);
    bus_in.vblnk = 1'b1;
    bus_in.vsync = 1'b1;
    repeat (20) @(negedge clk);
    bus_in.vblnk = 1'b0;
    bus_in.vsync = 1'b0;
  endtask

  task automatic write_val(input logic [11:0] d, input logic [3:0] ch, output logic ok);
    @(negedge clk);
    vdata  = d;
    vch    = ch;
    vvalid = 1'b1;
    ok     = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (rdy0) ok = 1'b1;
      @(negedge clk);
    end
    vvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vvalid = 1'b0; vdata = '0; vch = '0;
    bus_in = '0;
    bus_in.hcount = 11'd100; bus_in.vcount = 11'd200; bus_in.hsync = 1'b1; bus_in.rgb = BG;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (vout0 !== '0) begin n_err++; $display("FAIL reset_vga_out got=%h exp=0", vout0); end
    n_cmp++;
    if (rdy0 !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", rdy0); end
    rst_n = 1'b1;
    n_cmp++;
    if (rdy0 !== 1'b0) begin n_err++; $display("FAIL ready_at_release got=%b exp=0", rdy0); end
    @(negedge clk);
    n_cmp++;
    if (rdy0 !== 1'b1) begin n_err++; $display("FAIL ready_after_release got=%b exp=1", rdy0); end
  endtask

  task automatic test_passthrough();
    vga_bus_t hist [8];
    for (int i = 0; i < 8; i++) begin
      hist[i]        = '0;
      hist[i].hcount = 11'(60 + i * 7);
      hist[i].vcount = 11'(590 + i);
      hist[i].hsync  = i[0];
      hist[i].vsync  = i[1];
      hist[i].hblnk  = (i == 3);
      hist[i].vblnk  = (i == 5);
      hist[i].rgb    = BG;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        n_cmp++;
        if (out0 !== hist[i-2]) begin
          n_err++;
          $display("FAIL passthrough[%0d] got=%h exp=%h", i - 2, out0, hist[i-2]);
        end
      end
      if (i < 8) bus_in = hist[i];
      else begin bus_in = '0; bus_in.rgb = BG; end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_bar_shift0();
    logic ok;
    logic [11:0] got;
    int th [9] = '{64, 64, 64, 64, 64, 103, 63, 112, 64};
    int tv [9] = '{600, 346, 345, 344, 343, 500, 500, 500, 601};
    logic [11:0] te [9] = '{BAR, BAR, PK, PK, BG, BAR, BG, BG, BG};
    write_val(12'hFFF, 4'd0, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL write_ch0 accepted=%b exp=1", ok); end
    run_frame();
    for (int i = 0; i < 9; i++) begin
      sample_px(0, th[i], tv[i], 1'b0, got);
      n_cmp++;
      if (got !== te[i]) begin
        n_err++; $display("FAIL bar0_px(%0d,%0d) got=%h exp=%h", th[i], tv[i], got, te[i]);
      end
    end
    for (int h = 104; h <= 111; h++) begin
      sample_px(0, h, 500, 1'b0, got);
      n_cmp++;
      if (got !== BG) begin n_err++; $display("FAIL gap_px(%0d,500) got=%h exp=%h", h, got, BG); end
    end
    sample_px(0, 64, 500, 1'b1, got);
    n_cmp++;
    if (got !== BG) begin n_err++; $display("FAIL hblank_px got=%h exp=%h", got, BG); end
  endtask

  task automatic test_smooth();
    logic ok;
    logic [11:0] got;
    int tv1 [5] = '{538, 537, 536, 535, 600};
    logic [11:0] te1 [5] = '{BAR, PK, PK, BG, BAR};
    int tv2 [4] = '{490, 489, 488, 487};
    int tv3 [4] = '{346, 345, 344, 343};
    logic [11:0] te2 [4] = '{BAR, PK, PK, BG};
    write_val(12'hFF0, 4'd3, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL write_ch3 accepted=%b exp=1", ok); end
    run_frame();
    for (int i = 0; i < 5; i++) begin
      sample_px(2, 208, tv1[i], 1'b0, got);
      n_cmp++;
      if (got !== te1[i]) begin
        n_err++; $display("FAIL smooth_f1(208,%0d) got=%h exp=%h", tv1[i], got, te1[i]);
      end
    end
    sample_px(0, 208, 346, 1'b0, got);
    n_cmp++;
    if (got !== BAR) begin n_err++; $display("FAIL noshift_ch3 got=%h exp=%h", got, BAR); end
    run_frame();
    for (int i = 0; i < 4; i++) begin
      sample_px(2, 208, tv2[i], 1'b0, got);
      n_cmp++;
      if (got !== te2[i]) begin
        n_err++; $display("FAIL smooth_f2(208,%0d) got=%h exp=%h", tv2[i], got, te2[i]);
      end
    end
    repeat (20) run_frame();
    for (int i = 0; i < 4; i++) begin
      sample_px(2, 208, tv3[i], 1'b0, got);
      n_cmp++;
      if (got !== te2[i]) begin
        n_err++; $display("FAIL smooth_final(208,%0d) got=%h exp=%h", tv3[i], got, te2[i]);
      end
    end
  endtask

  task automatic test_peak_decay();
    logic ok;
    logic [11:0] got;
    int tv1 [5] = '{346, 345, 344, 347, 600};
    logic [11:0] te1 [5] = '{PK, PK, BG, BG, BG};
    int tv2 [2] = '{347, 345};
    int tv3 [2] = '{348, 346};
    logic [11:0] te2 [2] = '{PK, BG};
    write_val(12'h000, 4'd0, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL write_ch0_zero accepted=%b exp=1", ok); end
    run_frame();
    for (int i = 0; i < 5; i++) begin
      sample_px(0, 64, tv1[i], 1'b0, got);
      n_cmp++;
      if (got !== te1[i]) begin
        n_err++; $display("FAIL peak254(64,%0d) got=%h exp=%h", tv1[i], got, te1[i]);
      end
    end
    run_frame();
    for (int i = 0; i < 2; i++) begin
      sample_px(0, 64, tv2[i], 1'b0, got);
      n_cmp++;
      if (got !== te2[i]) begin
        n_err++; $display("FAIL peak253(64,%0d) got=%h exp=%h", tv2[i], got, te2[i]);
      end
    end
    run_frame();
    for (int i = 0; i < 2; i++) begin
      sample_px(0, 64, tv3[i], 1'b0, got);
      n_cmp++;
      if (got !== te2[i]) begin
        n_err++; $display("FAIL peak252(64,%0d) got=%h exp=%h", tv3[i], got, te2[i]);
      end
    end
  endtask

  task automatic test_hold_off();
    logic ok;
    logic [11:0] got;
    int cnt;
    int th [4] = '{160, 112, 640, 688};
    @(negedge clk);
    bus_in.vblnk = 1'b1;
    @(negedge clk);
    cnt = (rdy0 == 1'b0) ? 1 : 0;
    vdata = 12'hFFF; vch = 4'd2; vvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdy0 == 1'b0) cnt++;
      else break;
    end
    vvalid = 1'b0;
    n_cmp++;
    if (cnt !== 13) begin n_err++; $display("FAIL hold_off_cycles got=%0d exp=13", cnt); end
    bus_in.vblnk = 1'b0;
    write_val(12'hFFF, 4'd13, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL write_ch13 accepted=%b exp=1", ok); end
    run_frame();
    for (int i = 0; i < 4; i++) begin
      sample_px(0, th[i], 600, 1'b0, got);
      n_cmp++;
      if (got !== BG) begin
        n_err++; $display("FAIL no_bar(%0d,600) got=%h exp=%h", th[i], got, BG);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] got;
    int tv [5] = '{600, 473, 472, 471, 470};
    logic [11:0] te [5] = '{BAR, BAR, PK, PK, BG};
    @(negedge clk);
    vdata = 12'h800; vch = 4'd1; vvalid = 1'b1;
    bus_in.vblnk = 1'b1;
    @(negedge clk);
    vvalid = 1'b0;
    n_cmp++;
    if (rdy0 !== 1'b0) begin n_err++; $display("FAIL b2b_ready got=%b exp=0", rdy0); end
    repeat (18) @(negedge clk);
    bus_in.vblnk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_px(0, 112, tv[i], 1'b0, got);
      n_cmp++;
      if (got !== te[i]) begin
        n_err++; $display("FAIL b2b_px(112,%0d) got=%h exp=%h", tv[i], got, te[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] got;
    int ts [6] = '{0, 0, 0, 0, 2, 2};
    int th [6] = '{64, 64, 112, 112, 208, 208};
    int tv [6] = '{349, 350, 600, 472, 600, 345};
    @(negedge clk);
    bus_in = '0;
    bus_in.hcount = 11'd300; bus_in.vcount = 11'd100; bus_in.hsync = 1'b1;
    bus_in.vblnk = 1'b1; bus_in.rgb = BG;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (vout0 !== '0) begin n_err++; $display("FAIL midreset_out0 got=%h exp=0", vout0); end
    n_cmp++;
    if (vout2 !== '0) begin n_err++; $display("FAIL midreset_out2 got=%h exp=0", vout2); end
    n_cmp++;
    if (rdy0 !== 1'b0) begin n_err++; $display("FAIL midreset_ready got=%b exp=0", rdy0); end
    @(negedge clk);
    bus_in.vblnk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rdy0 !== 1'b1) begin n_err++; $display("FAIL midreset_ready_back got=%b exp=1", rdy0); end
    run_frame();
    for (int i = 0; i < 6; i++) begin
      sample_px(ts[i], th[i], tv[i], 1'b0, got);
      n_cmp++;
      if (got !== BG) begin
        n_err++; $display("FAIL after_reset(%0d,%0d,%0d) got=%h exp=%h", ts[i], th[i], tv[i], got, BG);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_bar_shift0();
    test_smooth();
    test_peak_decay();
    test_hold_off();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/vga_draw_bar_graph.md
# vga_draw_bar_graph

Parametrised VGA pipeline stage that overlays one vertical bar per measurement channel on the incoming picture. It sits on the VGA bus after the background stage and before the output register stage. Each bar shows a per-channel value written over a valid/ready port. Bar heights are updated once per frame during vertical blanking, with optional exponential smoothing and a decaying peak-hold marker.

## Interface
Parameters:
- CHANNELS, 13: number of bars (1..16).
- VALUE_W, 12: width of written values.
- HEIGHT_W, 8: bar height bits; height = value[VALUE_W-1 -: HEIGHT_W], max 2^HEIGHT_W-1 px.
- X0, 64: hcount of left edge of bar 0.
- Y0, 600: vcount of bar baseline (bottom row).
- BAR_W, 40: bar width in px.
- BAR_GAP, 8: gap between bars; PITCH = BAR_W+BAR_GAP.
- SMOOTH_SHIFT, 0: smoothing divisor exponent; 0 = no smoothing.
- BAR_COLOR, 12'h0_f_0; PEAK_COLOR, 12'hf_0_0.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- vga_in  in  `VGA_BUS_SIZE  upstream VGA bus (hcount, vcount, hs, vs, hblnk, vblnk, rgb).
- vga_out  out  `VGA_BUS_SIZE  delayed bus with overlay.
- value_data  in  VALUE_W  value to store.
- value_ch  in  4  target channel index.
- value_valid  in  1  write request.
- value_ready  out  1  write accepted when valid && ready.

## Operation
- Per channel: target[ch], disp[ch], peak[ch], each HEIGHT_W bits.
- Write: on valid && ready, target[value_ch] <= height(value_data). value_ch >= CHANNELS is accepted and dropped.
- Frame trigger: rising edge of vblnk_in, detected against a registered copy.
- Update FSM:
  - IDLE: value_ready=1. On trigger, go to UPD with idx=0.
  - UPD: value_ready=0. Processes channel idx each cycle. After idx=CHANNELS-1, returns to IDLE. Takes exactly CHANNELS cycles.
  - A trigger during UPD is ignored.
- Smoothing, per channel in UPD:
  - diff = target − disp, signed, HEIGHT_W+1 bits.
  - step = diff >>> SMOOTH_SHIFT.
  - If step==0 and diff≠0, step = sign(diff), so the bar always converges.
  - disp <= disp + step. With SMOOTH_SHIFT=0, disp <= target.
- Peak, same cycle, using the new disp: if new disp > peak, then peak <= new disp; else if peak>0, peak <= peak−1.
- Pixel rule, evaluated on the stage-1 registered coordinates:
  - Geometry: rel = hcount−X0; ch = rel/PITCH; column when hcount ≥ X0, ch < CHANNELS and rel%PITCH < BAR_W. Column tracking must use no divider; a running pitch counter is allowed.
  - Priority 1, blanking (hblnk or vblnk): rgb = rgb_in.
  - Priority 2: column and peak[ch]>0 and vcount ∈ {Y0−peak−1, Y0−peak} → PEAK_COLOR.
  - Priority 3: column and Y0−disp[ch] < vcount ≤ Y0 → BAR_COLOR.
  - Otherwise rgb_in.
- disp and peak change only during vblank, so the picture never tears.

## Timing
- Latency: 2 clk. All vga_out fields equal vga_in delayed by 2 cycles; rgb is per the pixel rule.
- value_ready is registered. It is 0 in the cycle after the trigger is seen and returns to 1 the cycle after the last UPD channel.
- A write and a trigger in the same cycle: the write completes, and the FSM enters UPD next cycle using the new target.
- Reset (async assert, sync deassert internally):
  - vga_out all zero; value_ready=0.
  - All target, disp and peak = 0; FSM in IDLE.
  - value_ready=1 on the first clk after release.
- Reset mid-UPD aborts the update and clears all state; no partial values survive.

## Structure
- Shared include `_bar_graph_defs.vh`: default colours and geometry defaults. The VGA bus split/merge macros come from `_vga_macros.vh`.
- Local parameters: PITCH, CH_W.
- Sub-module `vga_bar_frame_update`: trigger detection, FSM, smoothing and peak registers. Exposes disp/peak read ports indexed by pixel channel.
- The top level holds the 2-stage pixel pipeline and the pitch tracker.

## Test plan
- Reset then idle frame: vga_in rgb 12'h1_8_9 → vga_out rgb 12'h1_8_9 everywhere, sync fields delayed exactly 2 clk, value_ready=1 one cycle after release.
- SMOOTH_SHIFT=0, write ch0=12'hFFF, one frame:
  - (64,600) and (64,346) → 12'h0_f_0.
  - (64,345) and (64,344) → 12'hf_0_0.
  - (64,343) → background.
  - (104..111,500) gap → background.
- SMOOTH_SHIFT=2, ch3 target 255 from 0 → disp 63 after frame 1, 111 after frame 2, 255 eventually; peak tracks disp.
- After peak=255, write ch0=0 (shift 0) → disp 0, peak 254, 253, 252 on successive frames; marker rows move down 1 px per frame.
- Write during UPD is held off (ready=0 for 13 cycles). Write with value_ch=13 is accepted and no bar changes.
- Assert rst_n low mid-UPD and mid-line → outputs 0 immediately; after release all bars absent until new writes.
